// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state encoding, default parameters and counter
// width helper for the push-button debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_LONG_CYCLES   = 64;

    // Bits needed to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage single-bit synchronizer for an asynchronous input.
// The chain clears to 0 on the asynchronous active-high reset.
module sync_ff
    import key_debounce_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage further into the clock domain each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: synchronizes and debounces one active-high push-button,
// producing a clean level plus one-cycle press and release strobes.
// Optional long-press detection is built when KEY_DEBOUNCE_LONG_PRESS_EN is
// defined; otherwise long_press is tied low and the port list is unchanged.
module key_debounce_pulse
    import key_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic clk_out,
    input  logic rst,
    input  logic pb_in,
    output logic pb_level,
    output logic pb_pulse,
    output logic pb_release,
    output logic long_press
);

    localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             pb_sync;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pb_level_q, pb_level_d;
    logic             pb_pulse_q, pb_pulse_d;
    logic             pb_release_q, pb_release_d;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk_out),
        .rst (rst),
        .d   (pb_in),
        .q   (pb_sync)
    );

    // Next-state and stability counter: a change is accepted only after
    // STABLE_CYCLES identical synchronized samples; any contrary sample
    // returns to the previous stable state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pb_sync) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!pb_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!pb_sync) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_CHK: begin
                if (pb_sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with the state register; strobes fire only on the accepting transitions.
    always_comb begin
        pb_level_d   = (state_d == HELD) || (state_d == RELEASE_CHK);
        pb_pulse_d   = (state_q == PRESS_CHK) && (state_d == HELD);
        pb_release_d = (state_q == RELEASE_CHK) && (state_d == IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pb_level_q   <= 1'b0;
            pb_pulse_q   <= 1'b0;
            pb_release_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pb_level_q   <= pb_level_d;
            pb_pulse_q   <= pb_pulse_d;
            pb_release_q <= pb_release_d;
        end
    end

    assign pb_level   = pb_level_q;
    assign pb_pulse   = pb_pulse_q;
    assign pb_release = pb_release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int                HOLD_W   = cnt_width(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_press_q, long_press_d;

    // Hold counter: restarts on a fresh press, keeps counting through release
    // bounces, saturates at LONG_CYCLES and clears once the release is accepted.
    always_comb begin
        hold_d = hold_q;
        if ((state_q == PRESS_CHK) && (state_d == HELD)) begin
            hold_d = '0;
        end else if ((state_q == RELEASE_CHK) && (state_d == IDLE)) begin
            hold_d = '0;
        end else if (((state_q == HELD) || (state_q == RELEASE_CHK)) &&
                     (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
        end
        long_press_d = (hold_d == HOLD_MAX);
    end

    // Hold counter and long-press output registers.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            hold_q       <= '0;
            long_press_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            long_press_q <= long_press_d;
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: directed self-checking bench for key_debounce_pulse.
module tb_key_debounce_pulse;

    logic clk_out = 1'b0;
    logic rst     = 1'b0;
    logic pb_in   = 1'b0;
    logic pb_level;
    logic pb_pulse;
    logic pb_release;
    logic long_press;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit       pb;
        bit [3:0] expv;
    } vec_t;

    vec_t vecs[$];

    key_debounce_pulse dut (
        .clk_out    (clk_out),
        .rst        (rst),
        .pb_in      (pb_in),
        .pb_level   (pb_level),
        .pb_pulse   (pb_pulse),
        .pb_release (pb_release),
        .long_press (long_press)
    );

    // Free-running system clock, rising edges at 5, 15, 25 ...
    always #5 clk_out = ~clk_out;

    // Drive inputs on the falling edge, then let one rising edge pass and
    // settle before the caller samples.
    task automatic applyStimulus(input bit pb, input bit r);
        @(negedge clk_out);
        pb_in = pb;
        rst   = r;
        @(posedge clk_out);
        #1;
    endtask

    // Compare {level, pulse, release, long} against the expected pattern.
    task automatic checkOutput(input string name, input bit [3:0] expv);
        logic [3:0] act;
        act = {pb_level, pb_pulse, pb_release, long_press};
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b (level,pulse,release,long)",
                     name, act, expv);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int expv);
        tests_run++;
        if (act != expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic addVecs(input bit pb, input bit lvl, input bit pul,
                           input bit rel, input int n);
        vec_t v;
        v.pb   = pb;
        v.expv = {lvl, pul, rel, 1'b0};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        int lvl_rise;
        int lp_rise;
        bit lp_drop;
        bit [3:0] expv;

        // Table: idle, clean press/release, press bounce, release bounce.
        addVecs(0, 0, 0, 0, 3);
        addVecs(1, 0, 0, 0, 5);
        addVecs(1, 1, 1, 0, 1);
        addVecs(1, 1, 0, 0, 4);
        addVecs(0, 1, 0, 0, 5);
        addVecs(0, 0, 0, 1, 1);
        addVecs(0, 0, 0, 0, 4);
        addVecs(1, 0, 0, 0, 3);
        addVecs(0, 0, 0, 0, 1);
        addVecs(1, 0, 0, 0, 3);
        addVecs(0, 0, 0, 0, 7);
        addVecs(1, 0, 0, 0, 5);
        addVecs(1, 1, 1, 0, 1);
        addVecs(1, 1, 0, 0, 2);
        addVecs(0, 1, 0, 0, 2);
        addVecs(1, 1, 0, 0, 8);
        addVecs(0, 1, 0, 0, 5);
        addVecs(0, 0, 0, 1, 1);
        addVecs(0, 0, 0, 0, 4);

        #1 rst = 1'b1;
        #1 checkOutput("reset_immediate", 4'b0000);

        // Reset held while the button chatters every cycle.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(k[0], 1'b1);
            checkOutput($sformatf("reset_toggle_%0d", k), 4'b0000);
        end
        applyStimulus(1'b0, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pb, 1'b0);
            checkOutput($sformatf("vec_%0d", i), vecs[i].expv);
        end

        // Long hold: one pulse, level at edge 6, long_press at edge 70.
        pulses   = 0;
        lvl_rise = -1;
        lp_rise  = -1;
        lp_drop  = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (pb_pulse) pulses++;
            if (pb_level && lvl_rise < 0) lvl_rise = k;
            if (long_press && lp_rise < 0) lp_rise = k;
            if (lp_rise > 0 && !long_press) lp_drop = 1'b1;
        end
        checkValue("long_hold_pulses", pulses, 1);
        checkValue("long_hold_level_edge", lvl_rise, 6);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        checkValue("long_press_edge", lp_rise, 70);
        checkValue("long_press_dropped", int'(lp_drop), 0);
`else
        checkValue("long_press_edge", lp_rise, -1);
`endif
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            expv = {k < 6, 1'b0, k == 6, k < 6};
`else
            expv = {k < 6, 1'b0, k == 6, 1'b0};
`endif
            checkOutput($sformatf("long_release_%0d", k), expv);
        end

        // Reset mid-hold, then requalification of the still-held button.
        for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 1'b0);
        checkOutput("pre_reset_held", 4'b1000);
        #2 rst = 1'b1;
        #1 checkOutput("mid_cycle_reset", 4'b0000);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_hold_1", 4'b0000);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_hold_2", 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0);
            expv = {k >= 6, k == 6, 1'b0, 1'b0};
            checkOutput($sformatf("requalify_%0d", k), expv);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
